csr_ram_access_arbiter: RTL and testbench

CSR_RAM_ACCESS_ARBITER -- requirements
Module: csr_ram_access_arbiter

---
 rtl/csr_ram_access_arbiter_pkg.sv | 17 +
 rtl/csr_ram_access_arbiter_rr_grant_picker.sv | 39 +++
 rtl/csr_ram_access_arbiter.sv | 161 ++++++++++++++++
 tb/tb_csr_ram_access_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_ram_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_ram_access_arbiter_pkg
// Brief    : Shared types for the CSR/RAM access arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package csr_ram_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage : csr_ram_access_arbiter_pkg
`default_nettype wire

// File: rtl/csr_ram_access_arbiter_rr_grant_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_picker
// Brief    : Combinational round-robin pick starting after the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_picker
    import csr_ram_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    // Walk the offsets from farthest to nearest so the requester closest
    // after the last grant is the one left standing.
    always_comb begin : p_pick
        int cand;
        o_valid = 1'b0;
        o_idx   = '0;
        cand    = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = int'(i_last_grant) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (i_req[IDX_W'(cand)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(cand);
            end
        end
    end

endmodule : rr_grant_picker
`default_nettype wire

// File: rtl/csr_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csr_ram_access_arbiter
// Brief    : Round-robin arbiter funnelling N requesters onto one CSR bridge.
// Revision : 1.0 - initial release
// ============================================================================
module csr_ram_access_arbiter
    import csr_ram_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ             = 2,
    parameter int WORD_BIT_WIDTH      = 32,
    parameter int BYTE_ADDR_BIT_WIDTH = 8,
    parameter int ACK_TIMEOUT_CYCLES  = 16
) (
    input  logic                                               i_clk,
    input  logic                                               i_sync_rst,
    input  logic [NUM_REQ-1:0]                                 i_req,
    input  logic [NUM_REQ-1:0]                                 i_req_is_wr,
    input  logic [NUM_REQ-1:0][BYTE_ADDR_BIT_WIDTH-1:0]        i_byte_addr,
    input  logic [NUM_REQ-1:0][WORD_BIT_WIDTH-1:0]             i_wr_data,
    input  logic [NUM_REQ-1:0][WORD_BIT_WIDTH-1:0]             i_wr_bit_en,
    output logic [NUM_REQ-1:0]                                 o_ack,
    output logic [NUM_REQ-1:0]                                 o_err,
    output logic [WORD_BIT_WIDTH-1:0]                          o_rd_data,
    output logic                                               o_busy,
    output logic                                               o_acc_req,
    output logic                                               o_acc_req_is_wr,
    output logic [BYTE_ADDR_BIT_WIDTH-1:0]                     o_byte_addr,
    output logic [WORD_BIT_WIDTH-1:0]                          o_wr_data,
    output logic [WORD_BIT_WIDTH-1:0]                          o_wr_bit_en,
    input  logic                                               i_rd_ack,
    input  logic [WORD_BIT_WIDTH-1:0]                          i_rd_data,
    input  logic                                               i_wr_ack
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(ACK_TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);

    generate
        if (NUM_REQ < 2) begin : g_bad_num_req
            $error("csr_ram_access_arbiter: NUM_REQ must be >= 2 (got %0d)", NUM_REQ);
        end
        if (ACK_TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("csr_ram_access_arbiter: ACK_TIMEOUT_CYCLES must be >= 2 (got %0d)",
                   ACK_TIMEOUT_CYCLES);
        end
    endgenerate

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [c_IDX_W-1:0]  r_last_grant;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err;
    logic                w_pick_valid;
    logic [c_IDX_W-1:0]  w_pick_idx;
    logic                w_ack_match;
    logic                w_expire;

    rr_grant_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_picker (
        .i_req        (i_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_idx        (w_pick_idx)
    );

    // Only the ack type matching the outstanding access counts.
    assign w_ack_match = o_acc_req_is_wr ? i_wr_ack : i_rd_ack;
    assign w_expire    = (r_cnt == c_CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_acc_req    = 1'b0;
        o_busy       = 1'b1;
        o_ack        = '0;
        o_err        = '0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (w_pick_valid) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_acc_req    = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_ack_match || w_expire) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                o_ack[r_last_grant] = 1'b1;
                o_err[r_last_grant] = r_err;
                w_next_state        = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The grant register doubles as the response target; bridge attributes
    // are only reloaded on the next grant so they stay stable meanwhile.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            r_last_grant    <= c_LAST_RST;
            r_cnt           <= '0;
            r_err           <= 1'b0;
            o_acc_req_is_wr <= 1'b0;
            o_byte_addr     <= '0;
            o_wr_data       <= '0;
            o_wr_bit_en     <= '0;
            o_rd_data       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_last_grant    <= w_pick_idx;
                        o_acc_req_is_wr <= i_req_is_wr[w_pick_idx];
                        o_byte_addr     <= i_byte_addr[w_pick_idx];
                        o_wr_data       <= i_wr_data[w_pick_idx];
                        o_wr_bit_en     <= i_wr_bit_en[w_pick_idx];
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end
                ST_WAIT: begin
                    // A matching ack in the expiry cycle takes priority.
                    if (w_ack_match) begin
                        r_err <= 1'b0;
                        if (!o_acc_req_is_wr) begin
                            o_rd_data <= i_rd_data;
                        end
                    end else if (w_expire) begin
                        r_err     <= 1'b1;
                        o_rd_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : csr_ram_access_arbiter
`default_nettype wire

// File: tb/tb_csr_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_ram_access_arbiter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_ram_access_arbiter;

    localparam int N = 3;
    localparam int W = 32;
    localparam int A = 8;
    localparam int T = 16;

    logic                   i_clk = 1'b0;
    logic                   i_sync_rst;
    logic [N-1:0]           i_req;
    logic [N-1:0]           i_req_is_wr;
    logic [N-1:0][A-1:0]    i_byte_addr;
    logic [N-1:0][W-1:0]    i_wr_data;
    logic [N-1:0][W-1:0]    i_wr_bit_en;
    logic [N-1:0]           o_ack;
    logic [N-1:0]           o_err;
    logic [W-1:0]           o_rd_data;
    logic                   o_busy;
    logic                   o_acc_req;
    logic                   o_acc_req_is_wr;
    logic [A-1:0]           o_byte_addr;
    logic [W-1:0]           o_wr_data;
    logic [W-1:0]           o_wr_bit_en;
    logic                   i_rd_ack;
    logic [W-1:0]           i_rd_data;
    logic                   i_wr_ack;

    int n_checks = 0;
    int n_pass   = 0;
    bit pending[N];
    int model_last;

    csr_ram_access_arbiter #(
        .NUM_REQ             (N),
        .WORD_BIT_WIDTH      (W),
        .BYTE_ADDR_BIT_WIDTH (A),
        .ACK_TIMEOUT_CYCLES  (T)
    ) dut (
        .i_clk           (i_clk),
        .i_sync_rst      (i_sync_rst),
        .i_req           (i_req),
        .i_req_is_wr     (i_req_is_wr),
        .i_byte_addr     (i_byte_addr),
        .i_wr_data       (i_wr_data),
        .i_wr_bit_en     (i_wr_bit_en),
        .o_ack           (o_ack),
        .o_err           (o_err),
        .o_rd_data       (o_rd_data),
        .o_busy          (o_busy),
        .o_acc_req       (o_acc_req),
        .o_acc_req_is_wr (o_acc_req_is_wr),
        .o_byte_addr     (o_byte_addr),
        .o_wr_data       (o_wr_data),
        .o_wr_bit_en     (o_wr_bit_en),
        .i_rd_ack        (i_rd_ack),
        .i_rd_data       (i_rd_data),
        .i_wr_ack        (i_wr_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first pending requester after the last grant.
    function automatic int model_pick();
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (model_last + i) % N;
            if (pending[c]) return c;
        end
        return -1;
    endfunction

    task automatic post_req(input int r, input bit is_wr, input logic [A-1:0] a,
                            input logic [W-1:0] d, input logic [W-1:0] be);
        i_req[r]       = 1'b1;
        i_req_is_wr[r] = is_wr;
        i_byte_addr[r] = a;
        i_wr_data[r]   = d;
        i_wr_bit_en[r] = be;
        pending[r]     = 1'b1;
    endtask

    task automatic post_rand(input int r);
        post_req(r, 1'($urandom_range(0, 1)), A'($urandom), $urandom, $urandom);
    endtask

    task automatic do_reset();
        i_sync_rst = 1'b1;
        i_req      = '0;
        i_rd_ack   = 1'b0;
        i_wr_ack   = 1'b0;
        for (int r = 0; r < N; r++) pending[r] = 1'b0;
        model_last = N - 1;
        repeat (2) @(negedge i_clk);
        i_sync_rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},    o_busy,          0);
        check_eq({tag, "_accreq"},  o_acc_req,       0);
        check_eq({tag, "_is_wr"},   o_acc_req_is_wr, 0);
        check_eq({tag, "_addr"},    o_byte_addr,     0);
        check_eq({tag, "_wdata"},   o_wr_data,       0);
        check_eq({tag, "_bit_en"},  o_wr_bit_en,     0);
        check_eq({tag, "_ack"},     o_ack,           0);
        check_eq({tag, "_err"},     o_err,           0);
        check_eq({tag, "_rd_data"}, o_rd_data,       0);
    endtask

    // One full transaction. lat = WAIT cycle (1-based) in which the bridge
    // answers; 0 or > T means the bridge stays silent long enough to time out.
    task automatic run_txn(input int lat, input bit wrong_inj, input bit rearm,
                           input logic [W-1:0] rdv, output int g_obs, output int issue_dly);
        int   g;
        int   n;
        int   resp_k;
        bit   exp_err;
        bit   is_wr;
        g         = model_pick();
        g_obs     = -1;
        issue_dly = -1;
        n         = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_acc_req && n < 6);
        check_eq("issue_seen", o_acc_req, 1);
        if (!o_acc_req) return;
        issue_dly = n;
        is_wr     = i_req_is_wr[g];
        check_eq("bridge_is_wr",  o_acc_req_is_wr, is_wr);
        check_eq("bridge_addr",   o_byte_addr,     i_byte_addr[g]);
        check_eq("bridge_wdata",  o_wr_data,       i_wr_data[g]);
        check_eq("bridge_bit_en", o_wr_bit_en,     i_wr_bit_en[g]);
        exp_err = (lat < 1 || lat > T);
        resp_k  = exp_err ? T + 1 : lat + 1;
        for (int k = 1; k <= resp_k; k++) begin
            @(negedge i_clk);
            i_rd_ack  = 1'b0;
            i_wr_ack  = 1'b0;
            i_rd_data = $urandom;
            if (k < resp_k) begin
                check_eq("wait_quiet", {o_acc_req, o_ack, o_busy}, 1);
                if (k == lat) begin
                    if (is_wr) begin
                        i_wr_ack = 1'b1;
                    end else begin
                        i_rd_ack  = 1'b1;
                        i_rd_data = rdv;
                    end
                end else if (wrong_inj) begin
                    if (is_wr) i_rd_ack = 1'b1;
                    else       i_wr_ack = 1'b1;
                end
            end else begin
                check_eq("resp_ack", o_ack, 64'(1) << g);
                check_eq("resp_err", o_err, exp_err ? (64'(1) << g) : 64'(0));
                check_eq("resp_acc_req", o_acc_req, 0);
                if (!is_wr) check_eq("resp_rd_data", o_rd_data, exp_err ? '0 : rdv);
                for (int i = 0; i < N; i++) if (o_ack[i]) g_obs = i;
            end
        end
        i_req[g]   = 1'b0;
        pending[g] = 1'b0;
        model_last = g;
        if (rearm) post_req(g, is_wr, i_byte_addr[g], i_wr_data[g], i_wr_bit_en[g]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g;
        int d;
        i_sync_rst  = 1'b1;
        i_req       = '0;
        i_req_is_wr = '0;
        i_byte_addr = '0;
        i_wr_data   = '0;
        i_wr_bit_en = '0;
        i_rd_ack    = 1'b0;
        i_wr_ack    = 1'b0;
        i_rd_data   = '0;
        for (int r = 0; r < N; r++) pending[r] = 1'b0;
        model_last  = N - 1;
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_sync_rst = 1'b0;

        // Single read, 1-cycle bridge
        post_req(0, 1'b0, 8'h08, '0, '0);
        run_txn(1, 1'b0, 1'b0, 32'hDEADBEEF, g, d);
        check_eq("single_grant", g, 0);
        check_eq("single_issue_cycle", d, 1);

        // Contention: two writes in the same cycle
        do_reset();
        post_req(0, 1'b1, 8'h10, 32'h1111_2222, 32'hFFFF_0000);
        post_req(1, 1'b1, 8'h20, 32'h3333_4444, 32'h0000_FFFF);
        run_txn(1, 1'b0, 1'b0, '0, g, d);
        check_eq("contend_first", g, 0);
        run_txn(2, 1'b0, 1'b0, '0, g, d);
        check_eq("contend_second", g, 1);

        // Fairness with both requests held
        do_reset();
        post_req(0, 1'b0, 8'h04, '0, '0);
        post_req(1, 1'b1, 8'h0C, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            run_txn(1 + (i % 3), 1'b0, 1'b1, $urandom, g, d);
            check_eq("fair_grant", g, i % 2);
        end

        // Timeout then normal service
        do_reset();
        post_req(0, 1'b0, 8'h30, '0, '0);
        run_txn(0, 1'b0, 1'b0, '0, g, d);
        post_req(0, 1'b0, 8'h34, '0, '0);
        run_txn(1, 1'b0, 1'b0, 32'h0BAD_F00D, g, d);
        check_eq("after_timeout_grant", g, 0);

        // Wrong-type acks ignored; matching ack in the expiry cycle wins
        post_req(0, 1'b0, 8'h40, '0, '0);
        run_txn(T, 1'b1, 1'b0, 32'hC0FF_EE00, g, d);
        post_req(1, 1'b1, 8'h44, 32'h1234_5678, 32'hFF00_FF00);
        run_txn(T, 1'b1, 1'b0, '0, g, d);
        post_req(2, 1'b0, 8'h48, '0, '0);
        run_txn(T + 1, 1'b1, 1'b0, 32'h5555_5555, g, d);

        // Reset while waiting on the bridge
        do_reset();
        post_req(0, 1'b0, 8'h50, '0, '0);
        d = 0;
        do begin
            @(negedge i_clk);
            d++;
        end while (!o_acc_req && d < 6);
        check_eq("rst_issue_seen", o_acc_req, 1);
        @(negedge i_clk);
        i_sync_rst = 1'b1;
        i_req      = '0;
        pending[0] = 1'b0;
        model_last = N - 1;
        @(negedge i_clk);
        check_all_zero("rst_wait");
        i_sync_rst = 1'b0;
        i_rd_ack   = 1'b1;
        i_rd_data  = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_rd_ack = 1'b0;
        check_eq("late_ack_ignored", {o_busy, o_ack, o_err}, 0);
        check_eq("late_ack_rd_data", o_rd_data, 0);
        post_req(0, 1'b0, 8'h54, '0, '0);
        post_req(1, 1'b0, 8'h58, '0, '0);
        run_txn(1, 1'b0, 1'b0, 32'h7777_8888, g, d);
        check_eq("post_rst_grant", g, 0);
        run_txn(3, 1'b0, 1'b0, 32'h9999_AAAA, g, d);

        // Randomized traffic
        do_reset();
        for (int it = 0; it < 60; it++) begin
            int lat;
            bit any;
            any = 1'b0;
            for (int r = 0; r < N; r++) begin
                if (!pending[r] && $urandom_range(0, 1) == 1) post_rand(r);
                if (pending[r]) any = 1'b1;
            end
            if (!any) post_rand(int'($urandom_range(0, N - 1)));
            lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, T + 2));
            run_txn(lat, 1'($urandom_range(0, 1)), 1'b0, $urandom, g, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_csr_ram_access_arbiter
`default_nettype wire
